// File: rtl/step_responder.sv
// Execution-side responder for the instruction-step handshake.
// Sequences FETCH, EXEC, optional MEM and WB with a per-stage watchdog.
module step_responder #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  output logic             done,
  output logic             fetch_go,
  input  logic             fetch_ack,
  output logic             exec_go,
  input  logic             exec_ack,
  input  logic             is_mem,
  output logic             mem_go,
  input  logic             mem_ack,
  output logic             wb_en,
  output logic             busy,
  output logic [2:0]       stage,
  output logic [CNT_W-1:0] retired,
  output logic [7:0]       timeout_count,
  output logic             timeout_flag
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     next;
  logic [7:0] cnt;
  logic       req_q;
  logic       ack;
  logic       waiting;
  logic       at_limit;
  logic       forced;
  logic       entry;

  assign at_limit = (cnt == LIMIT);
  assign entry    = (cnt == 8'd0);

  // Next-state, stage strobes and watchdog decision.
  always_comb begin
    next     = state;
    ack      = 1'b0;
    waiting  = 1'b0;
    fetch_go = 1'b0;
    exec_go  = 1'b0;
    mem_go   = 1'b0;
    wb_en    = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && !req_q) next = FETCH;
      end
      FETCH: begin
        waiting  = 1'b1;
        fetch_go = entry;
        ack      = fetch_ack;
        if (ack || at_limit) next = EXEC;
      end
      EXEC: begin
        waiting = 1'b1;
        exec_go = entry;
        ack     = exec_ack;
        if (ack) next = is_mem ? MEM : WB;
        else if (at_limit) next = WB;
      end
      MEM: begin
        waiting = 1'b1;
        mem_go  = entry;
        ack     = mem_ack;
        if (ack || at_limit) next = WB;
      end
      WB: begin
        wb_en = 1'b1;
        next  = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!req) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  assign forced = waiting && !ack && at_limit;
  assign busy   = (state != IDLE);
  assign stage  = state;

  // State, edge detect, wait counter and statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      req_q         <= 1'b1;
      cnt           <= 8'd0;
      retired       <= '0;
      timeout_count <= 8'd0;
      timeout_flag  <= 1'b0;
    end else begin
      state <= next;
      req_q <= req;
      if (next != state) cnt <= 8'd0;
      else if (waiting)  cnt <= cnt + 8'd1;
      else               cnt <= 8'd0;
      if (state == WB) retired <= retired + CNT_W'(1);
      if (forced) begin
        timeout_flag <= 1'b1;
        if (timeout_count != 8'hFF)
          timeout_count <= timeout_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_step_responder.sv
// Directed testbench for step_responder.
// One task per scenario with inline comparisons.
module tb_step_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       fetch_ack;
  logic       exec_ack;
  logic       is_mem;
  logic       mem_ack;
  logic       done;
  logic       fetch_go;
  logic       exec_go;
  logic       mem_go;
  logic       wb_en;
  logic       busy;
  logic [2:0] stage;
  logic [31:0] retired;
  logic [7:0] timeout_count;
  logic       timeout_flag;

  logic       s_done;
  logic       s_fetch_go;
  logic       s_exec_go;
  logic       s_mem_go;
  logic       s_wb_en;
  logic       s_busy;
  logic [2:0] s_stage;
  logic [2:0] s_retired;
  logic [7:0] s_timeout_count;
  logic       s_timeout_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  step_responder u_dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .fetch_go(fetch_go), .fetch_ack(fetch_ack),
    .exec_go(exec_go), .exec_ack(exec_ack), .is_mem(is_mem),
    .mem_go(mem_go), .mem_ack(mem_ack), .wb_en(wb_en),
    .busy(busy), .stage(stage), .retired(retired),
    .timeout_count(timeout_count), .timeout_flag(timeout_flag)
  );

  step_responder #(.TIMEOUT(16), .CNT_W(3)) u_small (
    .clk(clk), .reset(reset), .req(req), .done(s_done),
    .fetch_go(s_fetch_go), .fetch_ack(fetch_ack),
    .exec_go(s_exec_go), .exec_ack(exec_ack), .is_mem(is_mem),
    .mem_go(s_mem_go), .mem_ack(mem_ack), .wb_en(s_wb_en),
    .busy(s_busy), .stage(s_stage), .retired(s_retired),
    .timeout_count(s_timeout_count), .timeout_flag(s_timeout_flag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_step(output bit ok);
    ok  = 1'b0;
    req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0;
    fetch_ack = 1'b1; exec_ack = 1'b1;
    is_mem = 1'b0; mem_ack = 1'b1;
    tick(); tick();
    checks++;
    if ({stage, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state got %b exp 00000", {stage, busy, done});
    end
    checks++;
    if ({fetch_go, exec_go, mem_go, wb_en} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 0000",
               {fetch_go, exec_go, mem_go, wb_en});
    end
    checks++;
    if (retired !== 32'd0 || timeout_count !== 8'd0 || timeout_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_counters got %0h %0h %0b exp 0 0 0",
               retired, timeout_count, timeout_flag);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_no_mem();
    logic [4:0] got;
    logic [4:0] exp;
    req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      got = {fetch_go, exec_go, mem_go, wb_en, done};
      exp = {c == 1, c == 2, 1'b0, c == 3, c >= 4};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL no_mem_c%0d got %b exp %b", c, got, exp);
      end
    end
    req = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || stage !== 3'd0) begin
      errors++;
      $display("FAIL no_mem_release got %b %0d exp 0 0", done, stage);
    end
    checks++;
    if (retired !== 32'd1 || timeout_count !== 8'd0) begin
      errors++;
      $display("FAIL no_mem_counts got %0d %0d exp 1 0", retired, timeout_count);
    end
  endtask

  task automatic test_mem_delay();
    logic [2:0] exp_st [1:8];
    exp_st = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd5, 3'd5};
    is_mem = 1'b1; mem_ack = 1'b0;
    req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (stage !== exp_st[c] || mem_go !== (c == 3) || done !== (c >= 7)) begin
        errors++;
        $display("FAIL mem_delay_c%0d got st=%0d mg=%b d=%b exp st=%0d mg=%b d=%b",
                 c, stage, mem_go, done, exp_st[c], c == 3, c >= 7);
      end
      if (c == 5) mem_ack = 1'b1;
    end
    checks++;
    if (retired !== 32'd2) begin
      errors++;
      $display("FAIL mem_delay_retired got %0d exp 2", retired);
    end
    req = 1'b0; is_mem = 1'b0;
    tick();
  endtask

  task automatic test_fetch_timeout();
    logic [2:0] exp;
    fetch_ack = 1'b0;
    req = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      tick();
      exp = (c <= 16) ? 3'd1 : (c == 17) ? 3'd2 : (c == 18) ? 3'd4 : 3'd5;
      checks++;
      if (stage !== exp || fetch_go !== (c == 1)) begin
        errors++;
        $display("FAIL fetch_to_c%0d got st=%0d fg=%b exp st=%0d fg=%b",
                 c, stage, fetch_go, exp, c == 1);
      end
    end
    checks++;
    if (done !== 1'b1 || timeout_count !== 8'd1 || timeout_flag !== 1'b1) begin
      errors++;
      $display("FAIL fetch_to_end got d=%b tc=%0d tf=%b exp 1 1 1",
               done, timeout_count, timeout_flag);
    end
    req = 1'b0; fetch_ack = 1'b1;
    tick();
  endtask

  task automatic test_exec_ack_last();
    logic [2:0] exp;
    exec_ack = 1'b0; is_mem = 1'b1;
    req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp = (c == 1) ? 3'd1 : (c <= 17) ? 3'd2 :
            (c == 18) ? 3'd3 : (c == 19) ? 3'd4 : 3'd5;
      checks++;
      if (stage !== exp) begin
        errors++;
        $display("FAIL exec_last_c%0d got %0d exp %0d", c, stage, exp);
      end
      if (c == 17) exec_ack = 1'b1;
    end
    checks++;
    if (timeout_count !== 8'd1 || done !== 1'b1) begin
      errors++;
      $display("FAIL exec_last_tc got tc=%0d d=%b exp 1 1", timeout_count, done);
    end
    req = 1'b0; is_mem = 1'b0;
    tick();
  endtask

  task automatic test_req_through_reset();
    bit seen_busy;
    logic [2:0] exp_st [1:5];
    exp_st = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd0};
    req = 1'b1; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy) seen_busy = 1'b1;
    end
    checks++;
    if (seen_busy !== 1'b0) begin
      errors++;
      $display("FAIL held_req_start got busy=%b exp 0", seen_busy);
    end
    req = 1'b0;
    tick();
    req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++;
      if (stage !== exp_st[c] || done !== (c == 4)) begin
        errors++;
        $display("FAIL early_drop_c%0d got st=%0d d=%b exp st=%0d d=%b",
                 c, stage, done, exp_st[c], c == 4);
      end
      if (c == 2) req = 1'b0;
    end
    checks++;
    if (retired !== 32'd1) begin
      errors++;
      $display("FAIL early_drop_retired got %0d exp 1", retired);
    end
  endtask

  task automatic test_reset_mid_step();
    req = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({fetch_go, exec_go, mem_go, wb_en, done, busy} !== 6'b0 ||
        retired !== 32'd0 || timeout_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset got %b r=%0d tc=%0d exp 000000 0 0",
               {fetch_go, exec_go, mem_go, wb_en, done, busy},
               retired, timeout_count);
    end
    reset = 1'b0; req = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    bit ok;
    bit all_ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_step(ok);
      if (!ok) all_ok = 1'b0;
    end
    checks++;
    if (s_retired !== 3'd7 || retired !== 32'd7) begin
      errors++;
      $display("FAIL wrap_pre got %0d %0d exp 7 7", s_retired, retired);
    end
    run_step(ok);
    if (!ok) all_ok = 1'b0;
    checks++;
    if (s_retired !== 3'd0 || retired !== 32'd8) begin
      errors++;
      $display("FAIL wrap_post got %0d %0d exp 0 8", s_retired, retired);
    end
    checks++;
    if (all_ok !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done got %b exp 1", all_ok);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    bit all_ok = 1'b1;
    fetch_ack = 1'b0; exec_ack = 1'b0; mem_ack = 1'b0;
    for (int i = 0; i < 127; i++) begin
      run_step(ok);
      if (!ok) all_ok = 1'b0;
    end
    checks++;
    if (timeout_count !== 8'd254) begin
      errors++;
      $display("FAIL sat_254 got %0d exp 254", timeout_count);
    end
    run_step(ok);
    if (!ok) all_ok = 1'b0;
    checks++;
    if (timeout_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_255 got %0d exp 255", timeout_count);
    end
    run_step(ok);
    if (!ok) all_ok = 1'b0;
    checks++;
    if (timeout_count !== 8'd255 || timeout_flag !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold got %0d %b exp 255 1", timeout_count, timeout_flag);
    end
    checks++;
    if (all_ok !== 1'b1 || retired !== 32'd137) begin
      errors++;
      $display("FAIL sat_steps got ok=%b r=%0d exp 1 137", all_ok, retired);
    end
  endtask

  initial begin
    test_reset();
    test_no_mem();
    test_mem_delay();
    test_fetch_timeout();
    test_exec_ack_last();
    test_req_through_reset();
    test_reset_mid_step();
    test_wrap();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
